// File: rtl/multi_key_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_key_pkg : edge-mode encodings, repeat FSM states, counter width    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
package multi_key_pkg;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_BOTH   = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // One counter width shared by the debounce and hold/repeat timers.
  function automatic int cnt_width(input int db, input int hold, input int rep);
    int m;
    m = db;
    if (hold > m) m = hold;
    if (rep > m) m = rep;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_channel : sync, debounce, edge qualify and hold-to-repeat, 1 channel |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module key_channel #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int REP_CYCLES  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_trig,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       out_pulse,
  output logic       out_level,
  output logic       out_repeat
);
  import multi_key_pkg::*;

  localparam int             CNT_W     = cnt_width(DB_CYCLES, HOLD_CYCLES, REP_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  rep_state_e       state_q, state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             pulse_q, pulse_d;
  logic             rpt_q, rpt_d;

  logic w_rise, w_fall, w_press, w_fire, w_hold_ok, w_edge_hit;

  always_comb begin
    s1_d        = in_trig;
    s2_d        = s1_q;
    db_cnt_d    = '0;
    level_d     = level_q;
    level_dly_d = level_q;
    state_d     = state_q;
    rep_cnt_d   = '0;
    w_press     = 1'b0;
    w_fire      = 1'b0;
    w_edge_hit  = 1'b0;

    // A new level is accepted only after DB_CYCLES consecutive disagreeing samples.
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end

    w_rise    = level_q & ~level_dly_q;
    w_fall    = ~level_q & level_dly_q;
    w_hold_ok = level_q & en & (mode == MODE_REPEAT);

    case (state_q)
      IDLE: begin
        if ((mode == MODE_REPEAT) && en && w_rise) begin
          w_press = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!w_hold_ok) begin
          state_d = IDLE;
        end else if (rep_cnt_q == HOLD_LAST) begin
          w_fire  = 1'b1;
          state_d = REPEAT;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!w_hold_ok) begin
          state_d = IDLE;
        end else if (rep_cnt_q == REP_LAST) begin
          w_fire = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (mode)
      MODE_RISE: w_edge_hit = w_rise;
      MODE_FALL: w_edge_hit = w_fall;
      MODE_BOTH: w_edge_hit = w_rise | w_fall;
      default:   w_edge_hit = w_press | w_fire;
    endcase

    // Back-to-back strobes are suppressed so a consumer never sees a 2-cycle pulse.
    pulse_d = en & w_edge_hit & ~pulse_q;
    rpt_d   = pulse_d & w_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      state_q     <= IDLE;
      rep_cnt_q   <= '0;
      pulse_q     <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      state_q     <= state_d;
      rep_cnt_q   <= rep_cnt_d;
      pulse_q     <= pulse_d;
      rpt_q       <= rpt_d;
    end
  end

  assign out_pulse  = pulse_q;
  assign out_level  = level_q;
  assign out_repeat = rpt_q;

endmodule
`default_nettype wire

// File: rtl/multi_key_pulse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_key_pulse : CH independent debounced key-to-strobe channels        |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module multi_key_pulse #(
  parameter int CH          = 4,
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int REP_CYCLES  = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in_trig,
  input  logic [CH-1:0] en,
  input  logic [1:0]    mode,
  output logic [CH-1:0] out_pulse,
  output logic [CH-1:0] out_level,
  output logic [CH-1:0] out_repeat
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .REP_CYCLES (REP_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_trig   (in_trig[i]),
      .en        (en[i]),
      .mode      (mode),
      .out_pulse (out_pulse[i]),
      .out_level (out_level[i]),
      .out_repeat(out_repeat[i])
    );
  end

endmodule
`default_nettype wire
